// File: rtl/set_driver.sv
// Command sequencer for a SET engine: buffers commands in a small FIFO, issues them one at a time,
// waits for the engine result (or a timeout), and reports match/mismatch with saturating tallies.
module set_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_central,
  input  logic [11:0] cmd_radius,
  input  logic [1:0]  cmd_mode,
  input  logic [7:0]  cmd_expect,
  output logic        en,
  output logic [23:0] central,
  output logic [11:0] radius,
  output logic [1:0]  mode,
  input  logic        busy,
  input  logic        valid,
  input  logic [7:0]  candidate,
  output logic        res_valid,
  output logic [7:0]  res_candidate,
  output logic        res_match,
  output logic        res_timeout,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic        idle
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic [7:0]  exp_cnt;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

  state_t          state, state_next;
  cmd_t            mem [FIFO_DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [TW-1:0]   wait_cnt;
  logic [7:0]      exp_q;
  logic            push, pop, report_go, hit_match, timed_out, fifo_empty;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign timed_out  = (wait_cnt == TW'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (!fifo_empty && !busy) state_next = S_ISSUE;
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT:   if (valid || timed_out) state_next = S_REPORT;
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Control decode; a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    pop        = (state == S_IDLE) && (state_next == S_ISSUE);
    report_go  = (state == S_WAIT) && (state_next == S_REPORT);
    hit_match  = valid && (candidate == exp_q);
    cmd_ready  = !rst && ((count != CW'(FIFO_DEPTH)) || pop);
    push       = cmd_valid && cmd_ready;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{central: cmd_central, radius: cmd_radius,
                               mode: cmd_mode, exp_cnt: cmd_expect};
  end

  // Engine drive, wait timer, result reporting and tallies
  always_ff @(posedge clk) begin
    if (rst) begin
      en            <= 1'b0;
      central       <= '0;
      radius        <= '0;
      mode          <= '0;
      exp_q         <= '0;
      wait_cnt      <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_match     <= 1'b0;
      res_timeout   <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      idle          <= 1'b1;
    end else begin
      en        <= pop;
      res_valid <= report_go;
      idle      <= (count_next == '0) && (state_next == S_IDLE);
      if (pop) begin
        central <= head.central;
        radius  <= head.radius;
        mode    <= head.mode;
        exp_q   <= head.exp_cnt;
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
      if (report_go) begin
        res_candidate <= valid ? candidate : 8'd0;
        res_match     <= hit_match;
        res_timeout   <= !valid;
        if (hit_match) begin
          if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        end else begin
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_set_driver.sv
// Bench for set_driver: a SET-engine stand-in answers each issued command, and a result-level
// model predicts when each report appears and what it carries.
module tb_set_driver;

  localparam int TO = 15;

  logic        clk, rst, cmd_valid, cmd_ready, en, busy, valid;
  logic [23:0] cmd_central, central;
  logic [11:0] cmd_radius, radius;
  logic [1:0]  cmd_mode, mode;
  logic [7:0]  cmd_expect, candidate, res_candidate;
  logic        res_valid, res_match, res_timeout, idle;
  logic [15:0] pass_cnt, fail_cnt;

  set_driver #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_central(cmd_central), .cmd_radius(cmd_radius), .cmd_mode(cmd_mode),
    .cmd_expect(cmd_expect), .en(en), .central(central), .radius(radius), .mode(mode),
    .busy(busy), .valid(valid), .candidate(candidate), .res_valid(res_valid),
    .res_candidate(res_candidate), .res_match(res_match), .res_timeout(res_timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .idle(idle)
  );

  typedef struct {
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    logic [7:0]  e;
  } cmd_t;

  typedef struct {
    int         t;
    logic [7:0] cand;
    logic       to;
    logic       match;
  } exp_t;

  cmd_t       cmd_q[$];
  exp_t       exp_q[$];
  int         nchk = 0, nerr = 0;
  int         cyc = 0, en_cnt = 0, last_en = 0, lr_cyc = 0;
  int         eng_cd = 0, resp_delay = 4;
  logic [7:0] resp_cand = 8'd0, lr_cand = 8'd0;
  logic       resp_never = 1'b0, stray_req = 1'b0, lr_match = 1'b0, lr_to = 1'b0, busy_prev = 1'b0;
  int         m_pass = 0, m_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SET-engine stand-in: answers resp_delay cycles after en, or never
  initial forever begin
    @(posedge clk); #2;
    valid = 1'b0;
    if (rst) begin
      eng_cd = 0;
      stray_req = 1'b0;
    end else begin
      if (stray_req) begin
        valid = 1'b1; candidate = 8'h5A; stray_req = 1'b0;
      end
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin valid = 1'b1; candidate = resp_cand; end
      end
      if (en === 1'b1) begin
        if (cmd_q.size() == 0) chk("issue_without_cmd", 32'(en), 32'd0);
        else begin
          cmd_t c;
          exp_t e;
          c = cmd_q.pop_front();
          chk("issue_central", 32'(central), 32'(c.c));
          chk("issue_radius",  32'(radius),  32'(c.r));
          chk("issue_mode",    32'(mode),    32'(c.m));
          if (resp_never) begin
            e.t = cyc + TO + 2; e.cand = 8'd0; e.to = 1'b1; e.match = 1'b0;
          end else begin
            e.t = cyc + resp_delay + 1; e.cand = resp_cand; e.to = 1'b0;
            e.match = (resp_cand == c.e);
            eng_cd = resp_delay;
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // Compare process: every cycle checks report timing/content and tallies against the model
  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_cnt++;
      last_en = cyc;
      chk("en_while_busy", 32'(busy_prev), 32'd0);
    end
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.match) m_pass = (m_pass == 65535) ? m_pass : m_pass + 1;
      else         m_fail = (m_fail == 65535) ? m_fail : m_fail + 1;
      chk("res_valid",     32'(res_valid),     32'd1);
      chk("res_candidate", 32'(res_candidate), 32'(e.cand));
      chk("res_match",     32'(res_match),     32'(e.match));
      chk("res_timeout",   32'(res_timeout),   32'(e.to));
    end else if (res_valid === 1'b1) begin
      chk("res_unexpected", 32'(res_valid), 32'd0);
    end
    if (res_valid === 1'b1) begin
      lr_cyc = cyc; lr_cand = res_candidate; lr_match = res_match; lr_to = res_timeout;
    end
    if (rst === 1'b0) begin
      chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
      chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    end
    busy_prev = busy;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; busy = 1'b0; resp_never = 1'b0;
    cmd_q.delete(); exp_q.delete(); m_pass = 0; m_fail = 0;
    step(); step();
    chk("ready_in_reset", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready",     32'(cmd_ready), 32'd1);
    chk("rst_en",        32'(en),        32'd0);
    chk("rst_central",   32'(central),   32'd0);
    chk("rst_radius",    32'(radius),    32'd0);
    chk("rst_mode",      32'(mode),      32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_pass",      32'(pass_cnt),  32'd0);
    chk("rst_fail",      32'(fail_cnt),  32'd0);
    chk("rst_idle",      32'(idle),      32'd1);
    en_cnt = 0;
  endtask

  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                      input logic [7:0] e);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_expect = e;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) ok = 1'b1;
    end
    if (ok) cmd_q.push_back('{c: c, r: r, m: m, e: e});
    else    chk("push_timeout", 32'd0, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (exp_q.size() == 0 && cmd_q.size() == 0 && idle === 1'b1 && eng_cd == 0) done = 1'b1;
    end
    if (!done) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; busy = 1'b0; valid = 1'b0; candidate = 8'd0;
    cmd_central = '0; cmd_radius = '0; cmd_mode = '0; cmd_expect = '0;
    do_reset();

    // Single matching command
    resp_cand = 8'd13; resp_delay = 4;
    push(24'h344500, 12'h220, 2'd0, 8'd13);
    wait_done(60);
    chk("t1_en_pulses", 32'(en_cnt),           32'd1);
    chk("t1_latency",   32'(lr_cyc - last_en), 32'd5);
    chk("t1_cand",      32'(lr_cand),          32'd13);
    chk("t1_match",     32'(lr_match),         32'd1);
    chk("t1_pass",      32'(pass_cnt),         32'd1);
    chk("t1_fail",      32'(fail_cnt),         32'd0);

    // Mismatch
    do_reset();
    resp_cand = 8'd9;
    push(24'h123456, 12'h0AB, 2'd2, 8'd10);
    wait_done(60);
    chk("t2_cand",  32'(lr_cand),  32'd9);
    chk("t2_match", 32'(lr_match), 32'd0);
    chk("t2_fail",  32'(fail_cnt), 32'd1);
    chk("t2_pass",  32'(pass_cnt), 32'd0);

    // Back-pressure with busy held, then drain in order
    do_reset();
    resp_cand = 8'h21; busy = 1'b1;
    for (int i = 0; i < 4; i++) push(24'(32'h100 * (i + 1)), 12'(i + 3), 2'(i), 8'h21);
    chk("t3_ready_full", 32'(cmd_ready), 32'd0);
    repeat (5) step();
    chk("t3_ready_held", 32'(cmd_ready), 32'd0);
    chk("t3_no_en_busy", 32'(en_cnt),    32'd0);
    busy = 1'b0;
    push(24'hABCDEF, 12'hFFF, 2'd3, 8'h21);
    wait_done(200);
    chk("t3_en_pulses", 32'(en_cnt),   32'd5);
    chk("t3_pass",      32'(pass_cnt), 32'd5);

    // Timeout
    do_reset();
    resp_never = 1'b1;
    push(24'h000001, 12'h001, 2'd1, 8'd7);
    wait_done(80);
    chk("t4_latency", 32'(lr_cyc - last_en), 32'(TO + 2));
    chk("t4_timeout", 32'(lr_to),            32'd1);
    chk("t4_cand",    32'(lr_cand),          32'd0);
    chk("t4_fail",    32'(fail_cnt),         32'd1);

    // Reset mid-WAIT with two commands still queued
    do_reset();
    resp_never = 1'b1;
    for (int i = 0; i < 3; i++) push(24'(32'h55 + i), 12'h010, 2'd0, 8'd1);
    for (int i = 0; i < 20 && en_cnt == 0; i++) step();
    chk("t5_issued", 32'(en_cnt), 32'd1);
    repeat (4) step();
    do_reset();
    repeat (25) step();
    chk("t5_no_en",   32'(en_cnt),   32'd0);
    chk("t5_idle",    32'(idle),     32'd1);
    chk("t5_pass",    32'(pass_cnt), 32'd0);
    chk("t5_fail",    32'(fail_cnt), 32'd0);

    // Stray valid in IDLE with an empty FIFO
    stray_req = 1'b1;
    repeat (4) step();
    chk("t6_pass", 32'(pass_cnt),  32'd0);
    chk("t6_fail", 32'(fail_cnt),  32'd0);
    chk("t6_idle", 32'(idle),      32'd1);
    chk("t6_no_en", 32'(en_cnt),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/set_driver.md
SET_DRIVER -- requirements
Module: set_driver

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, number of buffered commands (power of 2, >=2); TIMEOUT, default 1023, maximum cycles to wait for valid.
REQ-002 Ports SHALL be, in order: clk input 1 rising-edge clock; rst input 1 reset, synchronous active-high; one clock, reset is synchronous and active-high.
REQ-003 cmd_valid input 1: upstream command present.
REQ-004 cmd_ready output 1: command FIFO not full.
REQ-005 cmd_central input 24 {x1,y1,x2,y2,...}; cmd_radius input 12 {r1,r2,...}; cmd_mode input 2; cmd_expect input 8 expected candidate count.
REQ-006 en output 1; central output 24; radius output 12; mode output 2: drive the SET engine.
REQ-007 busy input 1; valid input 1; candidate input 8: returned by the SET engine.
REQ-008 res_valid output 1 one-cycle result strobe; res_candidate output 8; res_match output 1; res_timeout output 1.
REQ-009 pass_cnt output 16; fail_cnt output 16; idle output 1 (FIFO empty and FSM in IDLE).

Function
REQ-010 Command accept SHALL occur on a cycle with cmd_valid=1 and cmd_ready=1; all 46 command bits SHALL be written as one FIFO entry.
REQ-011 FIFO SHALL use wrapping read/write pointers plus an occupancy count; cmd_ready=0 when count==FIFO_DEPTH.
REQ-012 Simultaneous push and pop on a full FIFO SHALL be allowed (the pop frees a slot in the same cycle); count unchanged.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, REPORT.
REQ-014 IDLE->ISSUE when FIFO non-empty and busy=0; otherwise stay in IDLE.
REQ-015 ISSUE SHALL last exactly one cycle: en=1, central/radius/mode driven from the FIFO head, head popped, expect latched; then go to WAIT.
REQ-016 en SHALL be 1 only in ISSUE; central/radius/mode SHALL hold their last issued values outside ISSUE.
REQ-017 WAIT SHALL count cycles from 0; valid=1 -> latch candidate, go to REPORT; count reaching TIMEOUT with valid=0 -> go to REPORT with the timeout flag set.
REQ-018 valid asserted during IDLE or ISSUE SHALL be ignored.
REQ-019 REPORT SHALL last one cycle: res_valid=1; res_candidate=latched candidate (0 on timeout); res_match=(candidate==expect) and not timeout; res_timeout=flag. Next state is IDLE.
REQ-020 Each REPORT SHALL increment pass_cnt if res_match=1, else fail_cnt; both counters SHALL saturate at 16'hFFFF.
REQ-021 Issue-to-issue spacing SHALL be at least 3 cycles (ISSUE, >=1 WAIT, REPORT) and SHALL never re-issue while busy=1.
REQ-022 Minimum latency from valid to res_valid SHALL be exactly 1 cycle.

Reset
REQ-023 While rst=1 at a clock edge: FSM->IDLE; FIFO emptied; en=0, central=0, radius=0, mode=0; res_valid=0, res_candidate=0, res_match=0, res_timeout=0; pass_cnt=fail_cnt=0; cmd_ready=0 during reset and 1 on the first cycle after it; timeout counter cleared.
REQ-024 Reset asserted mid-WAIT SHALL abandon the command with no res_valid pulse and no counter update.

Verification
REQ-025 Single command: central=24'h344500, radius=12'h220, mode=0, expect=8'd13; the SET model returns valid with candidate=13 four cycles after en -> one en pulse, res_valid one cycle after valid, res_match=1, pass_cnt=1.
REQ-026 Mismatch: expect=8'd10, model returns 8'd9 -> res_match=0, res_candidate=9, fail_cnt=1, pass_cnt unchanged.
REQ-027 Back-pressure: push 5 commands back-to-back with FIFO_DEPTH=4 and busy=1 held -> cmd_ready drops after the 4th accept, no en while busy=1; after busy=0, all 5 are issued in push order.
REQ-028 Timeout: TIMEOUT=15, model never asserts valid -> REPORT on cycle 16 of WAIT with res_timeout=1, res_candidate=0, fail_cnt=1.
REQ-029 Reset mid-WAIT with 2 commands queued -> after reset: idle=1, counters 0, no res_valid, en stays 0.
REQ-030 Stray valid=1 in IDLE with the FIFO empty -> no res_valid, counters unchanged.
